// File: rtl/rv_defines_pkg.sv
// Shared RV32I definitions for the fetch, decode and control blocks.
// Instruction constants, opcodes and fetch FSM state encodings live here.
package rv_defines;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

   localparam logic [6:0] OP_LOAD   = 7'b000_0011;
   localparam logic [6:0] OP_STORE  = 7'b010_0011;
   localparam logic [6:0] OP_R      = 7'b011_0011;
   localparam logic [6:0] OP_BRANCH = 7'b110_0011;
   localparam logic [6:0] OP_IMM    = 7'b001_0011;
   localparam logic [6:0] OP_SYSTEM = 7'b111_0011;

   localparam logic [1:0] FS_BOOT = 2'd0;
   localparam logic [1:0] FS_RUN  = 2'd1;
   localparam logic [1:0] FS_HALT = 2'd2;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: pc, instruction and valid bit.
// Bubble has priority over load; with neither asserted the contents hold.
module if_id_reg
   import rv_defines::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_bubble,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr,
   output logic        o_valid
);

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_valid;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n || i_bubble) begin
         r_pc    <= 32'd0;
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_pc    <= i_pc;
         r_instr <= i_instr;
         r_valid <= 1'b1;
      end
   end

   assign o_pc    = r_pc;
   assign o_instr = r_instr;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, boot/run/halt FSM, fetch counter and
// the IF/ID register, driving a synchronous-read instruction memory.
module fetch_stage
   import rv_defines::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   output logic             imem_en,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      if_id_pc,
   output logic [31:0]      if_id_instr,
   output logic             if_id_valid,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic [31:0]      r_pc;
   logic [31:0]      w_pc_next;
   logic [31:0]      w_target;
   logic             w_load;
   logic             w_bubble;
   logic             w_unused_tgt;
   logic [CNT_W-1:0] r_count;

   assign w_target     = {branch_target[31:2], 2'b00};
   assign w_unused_tgt = &{1'b0, branch_target[1:0]};

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_load       = 1'b0;
      w_bubble     = 1'b0;
      imem_en      = 1'b0;
      case (r_state)
         FS_BOOT: begin
            imem_en      = 1'b1;
            w_pc_next    = RESET_PC;
            w_bubble     = 1'b1;
            w_state_next = FS_RUN;
         end
         FS_RUN: begin
            imem_en = 1'b1;
            if (branch_taken) begin
               w_pc_next = w_target;
               w_bubble  = 1'b1;
            end else if (!stall) begin
               // imem_rdata is the word at r_pc, registered by the memory last cycle
               w_pc_next = r_pc + 32'd4;
               w_load    = 1'b1;
               if (imem_rdata == EBREAK_INSTR) w_state_next = FS_HALT;
            end
         end
         FS_HALT: begin
            if (branch_taken) begin
               imem_en      = 1'b1;
               w_pc_next    = w_target;
               w_bubble     = 1'b1;
               w_state_next = FS_RUN;
            end else if (!stall) begin
               w_bubble = 1'b1;
            end
         end
         default: w_state_next = FS_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= FS_BOOT;
         r_pc    <= RESET_PC;
         r_count <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         if (w_load) r_count <= r_count + CNT_W'(1);
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_bubble (w_bubble),
      .i_pc     (r_pc),
      .i_instr  (imem_rdata),
      .o_pc     (if_id_pc),
      .o_instr  (if_id_instr),
      .o_valid  (if_id_valid)
   );

   assign imem_addr   = w_pc_next;
   assign halted      = (r_state == FS_HALT);
   assign fetch_count = r_count;

endmodule
